uart_loader: RTL and testbench

Serial bootloader and run controller sitting directly upstream of the CPU. It consumes bytes from the UART receiver and writes program bytes into the shared 512x8 RAM through its write port. It then drives the CPU's start strobe and start address, and reports load status and CPU halt back over the UART transmitter. While the CPU is running, the loader is passive.

---
 rtl/uart_loader.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// uart_loader: serial bootloader and run controller in front of the CPU.
// Parses UART command frames, writes program bytes into the shared 512x8 RAM,
// launches the CPU at a given address and reports status bytes back over UART.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   rx_byte/received byte stream from the UART receiver
//   tx_byte/transmit response byte and one-cycle send strobe to the transmitter
//   is_transmitting  transmitter busy; responses wait until it is low
//   l_waddr/l_dwrite/l_write_en  RAM write port, one cycle per data byte
//   cpu_start        one-cycle CPU launch pulse
//   startaddr        CPU start address, held after the pulse
//   cpu_halted       one-cycle halt strobe from the CPU
//   running          high while the CPU owns the machine
module uart_loader #(
    parameter int unsigned TIMEOUT = 1200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       received,
    output logic [7:0] tx_byte,
    output logic       transmit,
    input  logic       is_transmitting,
    output logic [8:0] l_waddr,
    output logic [7:0] l_dwrite,
    output logic       l_write_en,
    output logic       cpu_start,
    output logic [8:0] startaddr,
    input  logic       cpu_halted,
    output logic       running
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 8;

    localparam logic [DW-1:0] CMD_LOAD = 8'h4C;
    localparam logic [DW-1:0] CMD_RUN  = 8'h52;
    localparam logic [DW-1:0] RSP_ACK  = 8'h06;
    localparam logic [DW-1:0] RSP_NAK  = 8'h15;
    localparam logic [DW-1:0] RSP_UNK  = 8'h3F;
    localparam logic [DW-1:0] RSP_HALT = 8'h48;

    typedef enum logic [3:0] {
        S_IDLE,
        S_L_AH,
        S_L_AL,
        S_L_LEN,
        S_L_DATA,
        S_L_CSUM,
        S_R_AH,
        S_R_AL,
        S_START,
        S_RUNNING,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] sum_q, sum_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] resp_q, resp_d;
    logic          hi_q, hi_d;

    logic [DW-1:0] tx_byte_q, tx_byte_d;
    logic          transmit_q, transmit_d;
    logic [AW-1:0] l_waddr_q, l_waddr_d;
    logic [DW-1:0] l_dwrite_q, l_dwrite_d;
    logic          l_write_en_q, l_write_en_d;
    logic          cpu_start_q, cpu_start_d;
    logic [AW-1:0] startaddr_q, startaddr_d;
    logic          running_q, running_d;

    logic timed_c;
    logic timeout_c;

    // Inter-byte timer runs only while a frame is in progress.
    always_comb begin
        timed_c = 1'b0;
        case (state_q)
            S_L_AH, S_L_AL, S_L_LEN, S_L_DATA, S_L_CSUM, S_R_AH, S_R_AL: timed_c = 1'b1;
            default: timed_c = 1'b0;
        endcase
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout_c = timed_c && !received && ((cnt_q + CW'(1)) == CW'(TIMEOUT));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (timeout_c) begin
            state_d = S_RESP;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (received) begin
                        if (rx_byte == CMD_LOAD)     state_d = S_L_AH;
                        else if (rx_byte == CMD_RUN) state_d = S_R_AH;
                        else                         state_d = S_RESP;
                    end
                end
                S_L_AH:   if (received) state_d = S_L_AL;
                S_L_AL:   if (received) state_d = S_L_LEN;
                S_L_LEN:  if (received) state_d = (rx_byte == '0) ? S_L_CSUM : S_L_DATA;
                S_L_DATA: if (received && rem_q == DW'(1)) state_d = S_L_CSUM;
                S_L_CSUM: if (received) state_d = S_RESP;
                S_R_AH:   if (received) state_d = S_R_AL;
                S_R_AL:   if (received) state_d = S_START;
                S_START:  state_d = S_RUNNING;
                S_RUNNING: if (cpu_halted) state_d = S_RESP;
                S_RESP:   if (!is_transmitting) state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output next values; pulses default low every cycle.
    always_comb begin
        addr_d       = addr_q;
        sum_d        = sum_q;
        rem_d        = rem_q;
        resp_d       = resp_q;
        hi_d         = hi_q;
        tx_byte_d    = tx_byte_q;
        transmit_d   = 1'b0;
        l_waddr_d    = l_waddr_q;
        l_dwrite_d   = l_dwrite_q;
        l_write_en_d = 1'b0;
        cpu_start_d  = 1'b0;
        startaddr_d  = startaddr_q;
        running_d    = running_q;

        if (!timed_c || received || timeout_c) cnt_d = '0;
        else                                   cnt_d = cnt_q + CW'(1);

        if (timeout_c) begin
            resp_d = RSP_NAK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (received) begin
                        sum_d = '0;
                        if (rx_byte != CMD_LOAD && rx_byte != CMD_RUN) resp_d = RSP_UNK;
                    end
                end
                S_L_AH, S_R_AH: if (received) hi_d = rx_byte[0];
                S_L_AL:  if (received) addr_d = {hi_q, rx_byte};
                S_L_LEN: if (received) rem_d = rx_byte;
                S_L_DATA: begin
                    if (received) begin
                        l_waddr_d    = addr_q;
                        l_dwrite_d   = rx_byte;
                        l_write_en_d = 1'b1;
                        addr_d       = addr_q + AW'(1);
                        sum_d        = sum_q + rx_byte;
                        rem_d        = rem_q - DW'(1);
                    end
                end
                S_L_CSUM: if (received) resp_d = (rx_byte == sum_q) ? RSP_ACK : RSP_NAK;
                S_R_AL:   if (received) startaddr_d = {hi_q, rx_byte};
                S_START: begin
                    cpu_start_d = 1'b1;
                    running_d   = 1'b1;
                end
                S_RUNNING: begin
                    if (cpu_halted) begin
                        running_d = 1'b0;
                        resp_d    = RSP_HALT;
                    end
                end
                S_RESP: begin
                    if (!is_transmitting) begin
                        tx_byte_d  = resp_q;
                        transmit_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            sum_q        <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            resp_q       <= '0;
            hi_q         <= 1'b0;
            tx_byte_q    <= '0;
            transmit_q   <= 1'b0;
            l_waddr_q    <= '0;
            l_dwrite_q   <= '0;
            l_write_en_q <= 1'b0;
            cpu_start_q  <= 1'b0;
            startaddr_q  <= '0;
            running_q    <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            sum_q        <= sum_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            resp_q       <= resp_d;
            hi_q         <= hi_d;
            tx_byte_q    <= tx_byte_d;
            transmit_q   <= transmit_d;
            l_waddr_q    <= l_waddr_d;
            l_dwrite_q   <= l_dwrite_d;
            l_write_en_q <= l_write_en_d;
            cpu_start_q  <= cpu_start_d;
            startaddr_q  <= startaddr_d;
            running_q    <= running_d;
        end
    end

    assign tx_byte    = tx_byte_q;
    assign transmit   = transmit_q;
    assign l_waddr    = l_waddr_q;
    assign l_dwrite   = l_dwrite_q;
    assign l_write_en = l_write_en_q;
    assign cpu_start  = cpu_start_q;
    assign startaddr  = startaddr_q;
    assign running    = running_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed testbench for uart_loader (TIMEOUT shortened to 16 cycles).
module tb_uart_loader;

    logic       clk;
    logic       rst;
    logic [7:0] rx_byte;
    logic       received;
    logic [7:0] tx_byte;
    logic       transmit;
    logic       is_transmitting;
    logic [8:0] l_waddr;
    logic [7:0] l_dwrite;
    logic       l_write_en;
    logic       cpu_start;
    logic [8:0] startaddr;
    logic       cpu_halted;
    logic       running;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Observed events, sampled on the falling edge; cycle stamps use cyc.
    logic [8:0] wa_q[$];
    logic [7:0] wd_q[$];
    int         wc_q[$];
    logic [7:0] txb_q[$];
    int         txc_q[$];
    int         start_cnt = 0;
    int         start_cyc = 0;

    uart_loader #(.TIMEOUT(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_byte         (rx_byte),
        .received        (received),
        .tx_byte         (tx_byte),
        .transmit        (transmit),
        .is_transmitting (is_transmitting),
        .l_waddr         (l_waddr),
        .l_dwrite        (l_dwrite),
        .l_write_en      (l_write_en),
        .cpu_start       (cpu_start),
        .startaddr       (startaddr),
        .cpu_halted      (cpu_halted),
        .running         (running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (l_write_en) begin
            wa_q.push_back(l_waddr);
            wd_q.push_back(l_dwrite);
            wc_q.push_back(cyc);
        end
        if (transmit) begin
            txb_q.push_back(tx_byte);
            txc_q.push_back(cyc);
        end
        if (cpu_start) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
    end

    task automatic clear_obs();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        txb_q.delete();
        txc_q.delete();
        start_cnt = 0;
    endtask

    // Called at a falling edge; the byte is sampled on the next rising edge.
    // Returns at the following falling edge, when cyc names that sampling edge.
    task automatic send_byte(input logic [7:0] b, output int scyc);
        rx_byte  = b;
        received = 1'b1;
        @(negedge clk);
        received = 1'b0;
        scyc     = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for at least one response byte.
    task automatic wait_tx(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (txb_q.size() != 0) break;
            @(negedge clk);
        end
        idle(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++; if (tx_byte !== 8'h00)   begin errors++; $display("FAIL reset_tx_byte got %h want 00", tx_byte); end
        checks++; if (transmit !== 1'b0)   begin errors++; $display("FAIL reset_transmit got %b want 0", transmit); end
        checks++; if (l_waddr !== 9'h000)  begin errors++; $display("FAIL reset_l_waddr got %h want 000", l_waddr); end
        checks++; if (l_dwrite !== 8'h00)  begin errors++; $display("FAIL reset_l_dwrite got %h want 00", l_dwrite); end
        checks++; if (l_write_en !== 1'b0) begin errors++; $display("FAIL reset_l_write_en got %b want 0", l_write_en); end
        checks++; if (cpu_start !== 1'b0)  begin errors++; $display("FAIL reset_cpu_start got %b want 0", cpu_start); end
        checks++; if (startaddr !== 9'h000) begin errors++; $display("FAIL reset_startaddr got %h want 000", startaddr); end
        checks++; if (running !== 1'b0)    begin errors++; $display("FAIL reset_running got %b want 0", running); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_load_wrap();
        logic [7:0] fr[8];
        logic [8:0] ea[3];
        logic [7:0] ed[3];
        int bc[8];
        int s;
        fr = '{8'h4C, 8'h01, 8'hFE, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31};
        ea = '{9'h1FE, 9'h1FF, 9'h000};
        ed = '{8'hAA, 8'hBB, 8'hCC};
        clear_obs();
        for (int i = 0; i < 8; i++) begin
            send_byte(fr[i], s);
            bc[i] = s;
        end
        wait_tx(20);
        checks++; if (wa_q.size() !== 3) begin errors++; $display("FAIL wrap_write_count got %0d want 3", wa_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < wa_q.size()) begin
                checks++; if (wa_q[i] !== ea[i]) begin errors++; $display("FAIL wrap_addr%0d got %h want %h", i, wa_q[i], ea[i]); end
                checks++; if (wd_q[i] !== ed[i]) begin errors++; $display("FAIL wrap_data%0d got %h want %h", i, wd_q[i], ed[i]); end
                // Write is visible in the cycle right after the sampling edge.
                checks++; if (wc_q[i] !== bc[4+i]) begin errors++; $display("FAIL wrap_latency%0d got %0d want %0d", i, wc_q[i], bc[4+i]); end
            end
        end
        checks++; if (txb_q.size() !== 1) begin errors++; $display("FAIL wrap_tx_count got %0d want 1", txb_q.size()); end
        if (txb_q.size() != 0) begin
            checks++; if (txb_q[0] !== 8'h06) begin errors++; $display("FAIL wrap_ack got %h want 06", txb_q[0]); end
            checks++; if (txc_q[0] !== bc[7] + 1) begin errors++; $display("FAIL wrap_resp_latency got %0d want %0d", txc_q[0], bc[7] + 1); end
        end
    endtask

    task automatic test_bad_csum();
        logic [7:0] fr[7];
        int s;
        fr = '{8'h4C, 8'h00, 8'h10, 8'h02, 8'h01, 8'h02, 8'h04};
        clear_obs();
        for (int i = 0; i < 7; i++) send_byte(fr[i], s);
        wait_tx(20);
        checks++; if (wa_q.size() !== 2) begin errors++; $display("FAIL nak_write_count got %0d want 2", wa_q.size()); end
        if (wa_q.size() == 2) begin
            checks++; if (wa_q[1] !== 9'h011 || wd_q[1] !== 8'h02) begin errors++; $display("FAIL nak_write1 got %h=%h want 011=02", wa_q[1], wd_q[1]); end
        end
        checks++; if (txb_q.size() !== 1 || txb_q[0] !== 8'h15) begin errors++; $display("FAIL nak_resp got n=%0d want one 15", txb_q.size()); end
    endtask

    task automatic test_len_zero();
        logic [7:0] fr[5];
        int s;
        fr = '{8'h4C, 8'h00, 8'h00, 8'h00, 8'h00};
        clear_obs();
        for (int i = 0; i < 5; i++) send_byte(fr[i], s);
        wait_tx(20);
        checks++; if (wa_q.size() !== 0) begin errors++; $display("FAIL len0_writes got %0d want 0", wa_q.size()); end
        checks++; if (txb_q.size() !== 1 || txb_q[0] !== 8'h06) begin errors++; $display("FAIL len0_resp got n=%0d want one 06", txb_q.size()); end
    endtask

    task automatic test_run();
        logic [7:0] junk[5];
        int s;
        int last;
        junk = '{8'h4C, 8'h00, 8'h00, 8'h01, 8'h55};
        clear_obs();
        send_byte(8'h52, s);
        send_byte(8'h00, s);
        send_byte(8'h40, last);
        idle(3);
        checks++; if (start_cnt !== 1) begin errors++; $display("FAIL run_start_count got %0d want 1", start_cnt); end
        checks++; if (start_cyc !== last + 1) begin errors++; $display("FAIL run_start_latency got %0d want %0d", start_cyc, last + 1); end
        checks++; if (startaddr !== 9'h040) begin errors++; $display("FAIL run_startaddr got %h want 040", startaddr); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running got %b want 1", running); end
        for (int i = 0; i < 5; i++) send_byte(junk[i], s);
        idle(3);
        checks++; if (wa_q.size() !== 0 || txb_q.size() !== 0) begin errors++; $display("FAIL run_ignore_rx got w=%0d t=%0d want 0 0", wa_q.size(), txb_q.size()); end
        cpu_halted = 1'b1;
        @(negedge clk);
        cpu_halted = 1'b0;
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL halt_running got %b want 0", running); end
        wait_tx(20);
        checks++; if (txb_q.size() !== 1 || txb_q[0] !== 8'h48) begin errors++; $display("FAIL halt_resp got n=%0d want one 48", txb_q.size()); end
        checks++; if (startaddr !== 9'h040) begin errors++; $display("FAIL halt_startaddr_hold got %h want 040", startaddr); end
    endtask

    task automatic test_timeout();
        logic [7:0] fr[6];
        int s;
        int last;
        fr = '{8'h4C, 8'h00, 8'h20, 8'h01, 8'h7E, 8'h7E};
        clear_obs();
        send_byte(8'h4C, s);
        send_byte(8'h00, last);
        wait_tx(40);
        // 16 idle edges expire the timer, the next edge registers transmit.
        checks++; if (txb_q.size() !== 1 || txb_q[0] !== 8'h15) begin errors++; $display("FAIL timeout_resp got n=%0d want one 15", txb_q.size()); end
        if (txc_q.size() != 0) begin
            checks++; if (txc_q[0] !== last + 17) begin errors++; $display("FAIL timeout_latency got %0d want %0d", txc_q[0], last + 17); end
        end
        clear_obs();
        for (int i = 0; i < 6; i++) send_byte(fr[i], s);
        wait_tx(20);
        checks++; if (wa_q.size() !== 1 || wa_q[0] !== 9'h020 || wd_q[0] !== 8'h7E) begin errors++; $display("FAIL after_timeout_write got n=%0d want one 020=7E", wa_q.size()); end
        checks++; if (txb_q.size() !== 1 || txb_q[0] !== 8'h06) begin errors++; $display("FAIL after_timeout_ack got n=%0d want one 06", txb_q.size()); end
    endtask

    task automatic test_timeout_boundary();
        logic [7:0] fr[5];
        int s;
        fr = '{8'h00, 8'h30, 8'h01, 8'h09, 8'h09};
        clear_obs();
        send_byte(8'h4C, s);
        idle(15);
        for (int i = 0; i < 5; i++) send_byte(fr[i], s);
        wait_tx(20);
        checks++; if (txb_q.size() !== 1 || txb_q[0] !== 8'h06) begin errors++; $display("FAIL boundary_resp got n=%0d want one 06", txb_q.size()); end
        checks++; if (wa_q.size() !== 1 || wa_q[0] !== 9'h030) begin errors++; $display("FAIL boundary_write got n=%0d want one at 030", wa_q.size()); end
    endtask

    task automatic test_unknown();
        int s;
        clear_obs();
        send_byte(8'h5A, s);
        wait_tx(20);
        checks++; if (txb_q.size() !== 1 || txb_q[0] !== 8'h3F) begin errors++; $display("FAIL unknown_resp got n=%0d want one 3F", txb_q.size()); end
    endtask

    task automatic test_tx_busy();
        int s;
        int drop;
        clear_obs();
        is_transmitting = 1'b1;
        send_byte(8'h5A, s);
        idle(6);
        checks++; if (txb_q.size() !== 0) begin errors++; $display("FAIL busy_hold got n=%0d want 0", txb_q.size()); end
        is_transmitting = 1'b0;
        drop = cyc;
        idle(5);
        checks++; if (txb_q.size() !== 1 || txb_q[0] !== 8'h3F) begin errors++; $display("FAIL busy_resp got n=%0d want one 3F", txb_q.size()); end
        if (txc_q.size() != 0) begin
            checks++; if (txc_q[0] !== drop + 1) begin errors++; $display("FAIL busy_latency got %0d want %0d", txc_q[0], drop + 1); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] pre[5];
        logic [7:0] fr[7];
        int s;
        pre = '{8'h4C, 8'h00, 8'h80, 8'h04, 8'h11};
        fr  = '{8'h4C, 8'h00, 8'h80, 8'h02, 8'h11, 8'h22, 8'h33};
        clear_obs();
        for (int i = 0; i < 5; i++) send_byte(pre[i], s);
        checks++; if (l_write_en !== 1'b1) begin errors++; $display("FAIL mid_prewrite got %b want 1", l_write_en); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (l_waddr !== 9'h000 || l_dwrite !== 8'h00 || l_write_en !== 1'b0) begin errors++; $display("FAIL mid_reset_ram got %h %h %b want 000 00 0", l_waddr, l_dwrite, l_write_en); end
        checks++; if (tx_byte !== 8'h00 || transmit !== 1'b0 || running !== 1'b0 || cpu_start !== 1'b0 || startaddr !== 9'h000) begin errors++; $display("FAIL mid_reset_ctl got tx=%h t=%b r=%b s=%b a=%h want zeros", tx_byte, transmit, running, cpu_start, startaddr); end
        clear_obs();
        for (int i = 0; i < 7; i++) send_byte(fr[i], s);
        wait_tx(20);
        checks++; if (wa_q.size() !== 2) begin errors++; $display("FAIL mid_fresh_writes got %0d want 2", wa_q.size()); end
        if (wa_q.size() == 2) begin
            checks++; if (wa_q[1] !== 9'h081 || wd_q[1] !== 8'h22) begin errors++; $display("FAIL mid_fresh_w1 got %h=%h want 081=22", wa_q[1], wd_q[1]); end
        end
        checks++; if (txb_q.size() !== 1 || txb_q[0] !== 8'h06) begin errors++; $display("FAIL mid_fresh_ack got n=%0d want one 06", txb_q.size()); end
    endtask

    initial begin
        clk             = 1'b0;
        rst             = 1'b1;
        rx_byte         = 8'h00;
        received        = 1'b0;
        is_transmitting = 1'b0;
        cpu_halted      = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_wrap();
        test_bad_csum();
        test_len_zero();
        test_run();
        test_timeout();
        test_timeout_boundary();
        test_unknown();
        test_tx_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
